// File: rtl/saph_fpu_xbar.sv
// saph_fpu_xbar
//   Crossbar between GPUS shader-core request ports and FPUS identical
//   fixed-latency FPU pipelines. Each cycle, requesters are visited in
//   round-robin order starting at rr_ptr. Every valid requester takes the
//   lowest-index FPU that is ready, supports the requested mode, and has not
//   already been taken this cycle. A per-FPU tag pipeline of LATENCY stages
//   remembers who issued each operation, so the result returns to that
//   requester.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/mode/a/b  per-requester request (packed, requester 0 in LSBs)
//   req_ready           per-requester grant this cycle (combinational)
//   gpu_has_modes       OR of every FPU's capability mask (combinational)
//   resp_valid/data     per-requester result; data is 0 when not valid
//   pend_cnt            per-requester count of operations in flight
//   fpu_has_modes       per-FPU supported-mode mask
//   fpu_ready           per-FPU can accept a trigger this cycle
//   fpu_trig/mode/a/b   per-FPU issue; mode/operands are 0 when not triggered
//   fpu_res             per-FPU result, valid LATENCY cycles after fpu_trig
module saph_fpu_xbar #(
  parameter int GPUS    = 2,
  parameter int FPUS    = 2,
  parameter int LATENCY = 3,
  parameter int MODES   = 8,
  parameter int W       = 32,
  localparam int MB = (MODES > 1) ? $clog2(MODES) : 1,
  localparam int CW = $clog2(FPUS * LATENCY + 1),
  localparam int OW = (GPUS > 1) ? $clog2(GPUS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [GPUS-1:0]       req_valid,
  input  logic [GPUS*MB-1:0]    req_mode,
  input  logic [GPUS*W-1:0]     req_a,
  input  logic [GPUS*W-1:0]     req_b,
  output logic [GPUS-1:0]       req_ready,
  output logic [MODES-1:0]      gpu_has_modes,
  output logic [GPUS-1:0]       resp_valid,
  output logic [GPUS*W-1:0]     resp_data,
  output logic [GPUS*CW-1:0]    pend_cnt,
  input  logic [FPUS*MODES-1:0] fpu_has_modes,
  input  logic [FPUS-1:0]       fpu_ready,
  output logic [FPUS-1:0]       fpu_trig,
  output logic [FPUS*MB-1:0]    fpu_mode,
  output logic [FPUS*W-1:0]     fpu_a,
  output logic [FPUS*W-1:0]     fpu_b,
  input  logic [FPUS*W-1:0]     fpu_res
);

  localparam logic [CW-1:0] PEND_MAX = CW'(FPUS * LATENCY);

  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] grant_own [FPUS];

  logic          tag_vld_q [FPUS][LATENCY];
  logic          tag_vld_d [FPUS][LATENCY];
  logic [OW-1:0] tag_own_q [FPUS][LATENCY];
  logic [OW-1:0] tag_own_d [FPUS][LATENCY];

  logic [CW-1:0] pend_q [GPUS];
  logic [CW-1:0] pend_d [GPUS];

  logic          resp_collide;

  // Round-robin pointer advance; wraps at GPUS, which need not be a power of 2.
  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] p);
    if (int'(p) >= GPUS - 1) return '0;
    return p + 1'b1;
  endfunction

  // In-flight counter update, clamped to [0, PEND_MAX] so it can never wrap.
  function automatic logic [CW-1:0] cnt_update(input logic [CW-1:0] c,
                                               input logic inc,
                                               input logic dec);
    if (inc && !dec && c != PEND_MAX) return c + 1'b1;
    if (dec && !inc && c != '0)       return c - 1'b1;
    return c;
  endfunction

  // Capability lookup; a mode code beyond MODES is supported by nobody.
  function automatic logic mode_ok(input logic [FPUS*MODES-1:0] hm,
                                   input int f,
                                   input logic [MB-1:0] m);
    if (int'(m) >= MODES) return 1'b0;
    return hm[f*MODES + int'(m)];
  endfunction

  // Capability summary for the cores.
  always_comb begin
    gpu_has_modes = '0;
    for (int f = 0; f < FPUS; f++)
      gpu_has_modes = gpu_has_modes | fpu_has_modes[f*MODES +: MODES];
  end

  // Arbitration: greedy matching in round-robin visit order.
  always_comb begin
    logic [FPUS-1:0] taken;
    logic [MB-1:0]   m;
    logic            found;
    int              g;
    req_ready = '0;
    fpu_trig  = '0;
    fpu_mode  = '0;
    fpu_a     = '0;
    fpu_b     = '0;
    rr_ptr_d  = rr_ptr_q;
    taken     = '0;
    m         = '0;
    found     = 1'b0;
    g         = 0;
    for (int f = 0; f < FPUS; f++) grant_own[f] = '0;
    for (int k = 0; k < GPUS; k++) begin
      g     = (int'(rr_ptr_q) + k) % GPUS;
      m     = req_mode[g*MB +: MB];
      found = 1'b0;
      if (req_valid[g] && !rst) begin
        for (int f = 0; f < FPUS; f++) begin
          if (!found && !taken[f] && fpu_ready[f] && mode_ok(fpu_has_modes, f, m)) begin
            found                 = 1'b1;
            taken[f]              = 1'b1;
            req_ready[g]          = 1'b1;
            fpu_trig[f]           = 1'b1;
            fpu_mode[f*MB +: MB]  = m;
            fpu_a[f*W +: W]       = req_a[g*W +: W];
            fpu_b[f*W +: W]       = req_b[g*W +: W];
            grant_own[f]          = OW'(g);
            // Later visits overwrite this, leaving last-granted + 1.
            rr_ptr_d              = wrap_inc(OW'(g));
          end
        end
      end
    end
  end

  // Tag shift, response routing, in-flight accounting.
  always_comb begin
    resp_valid   = '0;
    resp_data    = '0;
    resp_collide = 1'b0;
    for (int f = 0; f < FPUS; f++) begin
      tag_vld_d[f][0] = fpu_trig[f];
      tag_own_d[f][0] = grant_own[f];
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld_d[f][s] = tag_vld_q[f][s-1];
        tag_own_d[f][s] = tag_own_q[f][s-1];
      end
      // Results in a reset cycle belong to dropped work and are suppressed.
      if (tag_vld_q[f][LATENCY-1] && !rst) begin
        if (resp_valid[tag_own_q[f][LATENCY-1]]) resp_collide = 1'b1;
        resp_valid[tag_own_q[f][LATENCY-1]]                   = 1'b1;
        resp_data[int'(tag_own_q[f][LATENCY-1])*W +: W]       = fpu_res[f*W +: W];
      end
    end
    for (int g = 0; g < GPUS; g++) begin
      pend_d[g]              = cnt_update(pend_q[g], req_ready[g], resp_valid[g]);
      pend_cnt[g*CW +: CW]   = pend_q[g];
    end
  end

  // ---- register boundary: control state (reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      for (int f = 0; f < FPUS; f++)
        for (int s = 0; s < LATENCY; s++)
          tag_vld_q[f][s] <= 1'b0;
      for (int g = 0; g < GPUS; g++) pend_q[g] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int f = 0; f < FPUS; f++)
        for (int s = 0; s < LATENCY; s++)
          tag_vld_q[f][s] <= tag_vld_d[f][s];
      for (int g = 0; g < GPUS; g++) pend_q[g] <= pend_d[g];
    end
  end

  // ---- register boundary: tag owners (qualified by tag_vld_q, no reset) ----
  always_ff @(posedge clk) begin
    for (int f = 0; f < FPUS; f++)
      for (int s = 0; s < LATENCY; s++)
        tag_own_q[f][s] <= tag_own_d[f][s];
  end

  // Fixed latency with one grant per requester per cycle makes two results
  // for the same requester in one cycle impossible.
  resp_unique_a: assert property (@(posedge clk) disable iff (rst) !resp_collide);

endmodule

// File: tb/tb_saph_fpu_xbar.sv
module tb_saph_fpu_xbar;
  localparam int GPUS = 2, FPUS = 2, LATENCY = 3, MODES = 8, W = 32;
  localparam int MB = 3, CW = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [GPUS-1:0]       req_valid;
  logic [GPUS*MB-1:0]    req_mode;
  logic [GPUS*W-1:0]     req_a, req_b;
  logic [GPUS-1:0]       req_ready;
  logic [MODES-1:0]      gpu_has_modes;
  logic [GPUS-1:0]       resp_valid;
  logic [GPUS*W-1:0]     resp_data;
  logic [GPUS*CW-1:0]    pend_cnt;
  logic [FPUS*MODES-1:0] fpu_has_modes;
  logic [FPUS-1:0]       fpu_ready;
  logic [FPUS-1:0]       fpu_trig;
  logic [FPUS*MB-1:0]    fpu_mode;
  logic [FPUS*W-1:0]     fpu_a, fpu_b;
  logic [FPUS*W-1:0]     fpu_res;

  saph_fpu_xbar #(.GPUS(GPUS), .FPUS(FPUS), .LATENCY(LATENCY), .MODES(MODES), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .gpu_has_modes(gpu_has_modes),
    .resp_valid(resp_valid), .resp_data(resp_data), .pend_cnt(pend_cnt),
    .fpu_has_modes(fpu_has_modes), .fpu_ready(fpu_ready),
    .fpu_trig(fpu_trig), .fpu_mode(fpu_mode), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_res(fpu_res)
  );

  always #5 clk = ~clk;

  // FPU environment: each FPU returns a+b exactly LATENCY cycles after its
  // trigger, and random garbage on cycles with no result.
  logic          pipe_vld [FPUS][LATENCY];
  logic [W-1:0]  pipe_val [FPUS][LATENCY];
  logic [W-1:0]  garb [FPUS];

  always @(posedge clk) begin
    for (int f = 0; f < FPUS; f++) begin
      pipe_vld[f][0] <= fpu_trig[f];
      pipe_val[f][0] <= fpu_a[f*W +: W] + fpu_b[f*W +: W];
      for (int s = 1; s < LATENCY; s++) begin
        pipe_vld[f][s] <= pipe_vld[f][s-1];
        pipe_val[f][s] <= pipe_val[f][s-1];
      end
      garb[f] <= $urandom;
    end
  end

  always_comb begin
    fpu_res = '0;
    for (int f = 0; f < FPUS; f++)
      fpu_res[f*W +: W] = pipe_vld[f][LATENCY-1] ? pipe_val[f][LATENCY-1] : garb[f];
  end

  // Reference model: round-robin pointer plus a list of outstanding results.
  typedef struct { int due; int g; logic [W-1:0] val; } resp_t;
  resp_t rq[$];
  int    rr_m = 0;
  int    cyc_n = 0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc_n, act, exp);
    end
  endtask

  // One clock cycle: compare DUT against the model at the falling edge,
  // then advance the model at the rising edge.
  task automatic tick(input bit en);
    logic [GPUS-1:0]     e_ready;
    logic [FPUS-1:0]     e_trig;
    logic [FPUS*MB-1:0]  e_mode;
    logic [FPUS*W-1:0]   e_a, e_b;
    logic [GPUS-1:0]     e_rv;
    logic [GPUS*W-1:0]   e_rd;
    logic [GPUS*CW-1:0]  e_pc;
    logic [MODES-1:0]    e_hm;
    resp_t               keep[$];
    int                  last_g, g, m, n;
    @(negedge clk);
    e_ready = '0; e_trig = '0; e_mode = '0; e_a = '0; e_b = '0;
    e_rv = '0; e_rd = '0; e_pc = '0; e_hm = '0;
    last_g = -1;
    for (int f = 0; f < FPUS; f++) e_hm = e_hm | fpu_has_modes[f*MODES +: MODES];
    if (!rst) begin
      for (int k = 0; k < GPUS; k++) begin
        g = (rr_m + k) % GPUS;
        m = int'(req_mode[g*MB +: MB]);
        if (req_valid[g]) begin
          for (int f = 0; f < FPUS; f++) begin
            if (!e_ready[g] && !e_trig[f] && fpu_ready[f] && fpu_has_modes[f*MODES + m]) begin
              e_ready[g] = 1'b1;
              e_trig[f] = 1'b1;
              e_mode[f*MB +: MB] = req_mode[g*MB +: MB];
              e_a[f*W +: W] = req_a[g*W +: W];
              e_b[f*W +: W] = req_b[g*W +: W];
              last_g = g;
            end
          end
        end
      end
      foreach (rq[i]) if (rq[i].due == cyc_n) begin
        e_rv[rq[i].g] = 1'b1;
        e_rd[rq[i].g*W +: W] = rq[i].val;
      end
    end
    for (int gg = 0; gg < GPUS; gg++) begin
      n = 0;
      foreach (rq[i]) if (rq[i].g == gg) n++;
      e_pc[gg*CW +: CW] = CW'(n);
    end
    if (en) begin
      chk("req_ready",     64'(req_ready),     64'(e_ready));
      chk("fpu_trig",      64'(fpu_trig),      64'(e_trig));
      chk("fpu_mode",      64'(fpu_mode),      64'(e_mode));
      chk("fpu_a",         64'(fpu_a),         64'(e_a));
      chk("fpu_b",         64'(fpu_b),         64'(e_b));
      chk("resp_valid",    64'(resp_valid),    64'(e_rv));
      chk("resp_data",     64'(resp_data),     64'(e_rd));
      chk("pend_cnt",      64'(pend_cnt),      64'(e_pc));
      chk("gpu_has_modes", 64'(gpu_has_modes), 64'(e_hm));
    end
    @(posedge clk);
    if (rst) begin
      rr_m = 0;
      rq.delete();
    end else begin
      foreach (rq[i]) if (rq[i].due != cyc_n) keep.push_back(rq[i]);
      rq = keep;
      for (int gg = 0; gg < GPUS; gg++)
        if (e_ready[gg]) rq.push_back('{cyc_n + LATENCY, gg, req_a[gg*W +: W] + req_b[gg*W +: W]});
      if (last_g >= 0) rr_m = (last_g + 1) % GPUS;
    end
    cyc_n++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick(1'b1);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  rv;
    logic [5:0]  rm;
    logic [1:0]  fr;
    logic [15:0] hm;
    logic [1:0]  xr;
    logic [1:0]  xt;
    logic [7:0]  xh;
  } vec_t;
  vec_t vt[8];

  initial begin
    int peak, nresp;
    // {req_valid, {mode1,mode0}, fpu_ready, {hm1,hm0}, exp ready, exp trig, exp has_modes}
    vt[0] = '{2'b01, 6'b000_010, 2'b11, 16'hFFFF, 2'b01, 2'b01, 8'hFF};
    vt[1] = '{2'b11, 6'b001_100, 2'b11, 16'h1002, 2'b11, 2'b11, 8'h12};
    vt[2] = '{2'b01, 6'b000_101, 2'b11, 16'h1002, 2'b00, 2'b00, 8'h12};
    vt[3] = '{2'b11, 6'b010_010, 2'b01, 16'hFFFF, 2'b01, 2'b01, 8'hFF};
    vt[4] = '{2'b11, 6'b010_010, 2'b00, 16'hFFFF, 2'b00, 2'b00, 8'hFF};
    vt[5] = '{2'b10, 6'b011_000, 2'b10, 16'hFFFF, 2'b10, 2'b10, 8'hFF};
    vt[6] = '{2'b11, 6'b000_000, 2'b11, 16'h0100, 2'b01, 2'b10, 8'h01};
    vt[7] = '{2'b00, 6'b000_000, 2'b11, 16'hFFFF, 2'b00, 2'b00, 8'hFF};

    rst = 1'b1; req_valid = '0; req_mode = '0; req_a = '0; req_b = '0;
    fpu_has_modes = '1; fpu_ready = '1;
    #1;
    tick(1'b0);
    do_reset();

    // Table: combinational arbitration from a freshly reset pointer.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      req_valid = vt[i].rv; req_mode = vt[i].rm; fpu_ready = vt[i].fr;
      fpu_has_modes = vt[i].hm;
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      #2;
      chk("vec_ready", 64'(req_ready), 64'(vt[i].xr));
      chk("vec_trig",  64'(fpu_trig),  64'(vt[i].xt));
      chk("vec_hm",    64'(gpu_has_modes), 64'(vt[i].xh));
      tick(1'b1);
      req_valid = '0;
      repeat (LATENCY + 1) tick(1'b1);
    end
    fpu_has_modes = '1; fpu_ready = '1;

    // Single request.
    do_reset();
    req_valid = 2'b01; req_mode = 6'b000_010; req_a = {32'h0, 32'h3F800000}; req_b = '0;
    #2;
    chk("single_ready", 64'(req_ready), 64'h1);
    tick(1'b1);
    req_valid = '0;
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk("single_pend", 64'(pend_cnt[CW-1:0]), (i <= 3) ? 64'd1 : 64'd0);
      chk("single_rv",   64'(resp_valid), (i == 3) ? 64'h1 : 64'h0);
      if (i == 3) chk("single_rd", 64'(resp_data[W-1:0]), 64'h3F800000);
      tick(1'b1);
    end

    // Contention on a single FPU: grants alternate.
    do_reset();
    req_valid = 2'b11; fpu_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      #2;
      chk("contend_ready", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick(1'b1);
    end
    req_valid = '0; fpu_ready = 2'b11;
    repeat (5) tick(1'b1);

    // Throughput: one requester issues every cycle.
    do_reset();
    peak = 0; nresp = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = (i < 10) ? 2'b01 : 2'b00;
      req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
      #2;
      if (int'(pend_cnt[CW-1:0]) > peak) peak = int'(pend_cnt[CW-1:0]);
      if (resp_valid[0]) nresp++;
      tick(1'b1);
    end
    chk("thru_peak", 64'(peak), 64'd3);
    chk("thru_nresp", 64'(nresp), 64'd10);

    // Reset mid-flight.
    do_reset();
    req_valid = 2'b11; req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    tick(1'b1);
    req_valid = 2'b01;
    tick(1'b1);
    rst = 1'b1; req_valid = '0;
    tick(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rstmid_rv",   64'(resp_valid), 64'h0);
      chk("rstmid_pend", 64'(pend_cnt),   64'h0);
      tick(1'b1);
    end
    req_valid = 2'b11; fpu_ready = 2'b01;
    #2;
    chk("rstmid_rr", 64'(req_ready), 64'h1);
    tick(1'b1);
    req_valid = '0; fpu_ready = 2'b11;
    repeat (5) tick(1'b1);

    // FPUs busy, then grants resume immediately.
    do_reset();
    req_valid = 2'b11; fpu_ready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("busy_trig", 64'(fpu_trig), 64'h0);
      tick(1'b1);
    end
    fpu_ready = 2'b11;
    #2;
    chk("resume_trig", 64'(fpu_trig), 64'h3);
    tick(1'b1);
    req_valid = '0;
    repeat (5) tick(1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) fpu_has_modes = 16'($urandom) | 16'h0101;
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = 2'($urandom);
      req_mode  = 6'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      fpu_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      tick(1'b1);
    end
    rst = 1'b0; req_valid = '0;
    repeat (LATENCY + 2) tick(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
